// File: rtl/vram_pkg.sv
// Shared constants and slot-type encoding for the VRAM arbiter.
package vram_pkg;

  localparam int VRAM_AW     = 18;
  localparam int VRAM_DW     = 8;
  localparam int WFIFO_DEPTH = 4;
  localparam int RD_LATENCY  = 3;

  typedef enum logic [1:0] {
    SLOT_IDLE = 2'd0,
    SLOT_VID  = 2'd1,
    SLOT_WR   = 2'd2,
    SLOT_RD   = 2'd3
  } slot_t;

endpackage

// File: rtl/vram_wfifo.sv
// Posted-write FIFO holding {address, data} pairs for CPU writes.
module vram_wfifo #(
  parameter int AW    = 18,
  parameter int DW    = 8,
  parameter int DEPTH = 4
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          i_push,
  input  logic [AW-1:0] i_push_addr,
  input  logic [DW-1:0] i_push_data,
  input  logic          i_pop,
  output logic [AW-1:0] o_head_addr,
  output logic [DW-1:0] o_head_data,
  output logic          o_full,
  output logic          o_empty
);
  import vram_pkg::*;

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] PTR_ONE = 1;

  logic [AW+DW-1:0] r_mem [DEPTH];
  logic [PW:0]      r_wptr;
  logic [PW:0]      r_rptr;
  logic             w_do_push;
  logic             w_do_pop;

  // Extra pointer MSB distinguishes full from empty when the low bits match.
  always_comb begin
    o_empty     = (r_wptr == r_rptr);
    o_full      = (r_wptr[PW] != r_rptr[PW]) && (r_wptr[PW-1:0] == r_rptr[PW-1:0]);
    w_do_push   = i_push & ~o_full;
    w_do_pop    = i_pop & ~o_empty;
    o_head_addr = r_mem[r_rptr[PW-1:0]][AW+DW-1:DW];
    o_head_data = r_mem[r_rptr[PW-1:0]][DW-1:0];
  end

  // Pointer update; both wrap modulo twice the depth.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + PTR_ONE;
      if (w_do_pop)  r_rptr <= r_rptr + PTR_ONE;
    end
  end

  // Entry storage, written at the tail.
  always_ff @(posedge clock) begin
    if (w_do_push) r_mem[r_wptr[PW-1:0]] <= {i_push_addr, i_push_data};
  end

endmodule

// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter: video reads first, then posted CPU writes,
// then a CPU read once all earlier writes have drained.
module vram_arbiter #(
  parameter int AW          = vram_pkg::VRAM_AW,
  parameter int DW          = vram_pkg::VRAM_DW,
  parameter int WFIFO_DEPTH = vram_pkg::WFIFO_DEPTH
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          vid_req,
  input  logic [AW-1:0] vid_address,
  output logic          vid_valid,
  output logic [DW-1:0] vid_data,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_address,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_ack,
  output logic [DW-1:0] cpu_rdata,
  output logic [AW-1:0] vram_address,
  output logic [DW-1:0] vram_wdata,
  output logic          vram_we,
  input  logic [DW-1:0] vram_q
);
  import vram_pkg::*;

  slot_t         r_slot [RD_LATENCY];
  slot_t         w_grant;
  logic          r_wr_ack;
  logic          r_rd_pend;
  logic          r_rd_busy;
  logic [AW-1:0] r_vram_address;
  logic [DW-1:0] r_vram_wdata;
  logic          r_vram_we;
  logic [DW-1:0] r_vid_data;
  logic [DW-1:0] r_cpu_rdata;

  logic          w_full;
  logic          w_empty;
  logic [AW-1:0] w_head_addr;
  logic [DW-1:0] w_head_data;
  logic          w_push;
  logic          w_pop;
  logic          w_rd_ack;
  logic          w_ack;
  logic          w_rd_new;
  logic          w_rd_want;

  vram_wfifo #(
    .AW    (AW),
    .DW    (DW),
    .DEPTH (WFIFO_DEPTH)
  ) u_wfifo (
    .clock       (clock),
    .reset_n     (reset_n),
    .i_push      (w_push),
    .i_push_addr (cpu_address),
    .i_push_data (cpu_wdata),
    .i_pop       (w_pop),
    .o_head_addr (w_head_addr),
    .o_head_data (w_head_data),
    .o_full      (w_full),
    .o_empty     (w_empty)
  );

  // Request acceptance and per-cycle slot grant. The request is still held
  // during its ack cycle, so nothing is accepted while an ack is on the port.
  always_comb begin
    w_rd_ack  = (r_slot[RD_LATENCY-1] == SLOT_RD);
    w_ack     = r_wr_ack | w_rd_ack;
    w_push    = cpu_req & cpu_we & ~w_ack & ~w_full;
    w_rd_new  = cpu_req & ~cpu_we & ~w_ack & ~r_rd_busy;
    w_rd_want = r_rd_pend | w_rd_new;
    w_grant   = SLOT_IDLE;
    if (vid_req)        w_grant = SLOT_VID;
    else if (!w_empty)  w_grant = SLOT_WR;
    else if (w_rd_want) w_grant = SLOT_RD;
    w_pop     = (w_grant == SLOT_WR);
  end

  // RAM drive, slot-type latency pipe and read-data capture.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < RD_LATENCY; i++) r_slot[i] <= SLOT_IDLE;
      r_wr_ack       <= 1'b0;
      r_rd_pend      <= 1'b0;
      r_rd_busy      <= 1'b0;
      r_vram_address <= '0;
      r_vram_wdata   <= '0;
      r_vram_we      <= 1'b0;
      r_vid_data     <= '0;
      r_cpu_rdata    <= '0;
    end else begin
      r_slot[0] <= w_grant;
      for (int unsigned i = 1; i < RD_LATENCY; i++) r_slot[i] <= r_slot[i-1];
      r_wr_ack  <= w_push;
      r_rd_pend <= w_rd_want & (w_grant != SLOT_RD);
      r_rd_busy <= (r_rd_busy | w_rd_new) & ~w_rd_ack;
      r_vram_we <= 1'b0;
      case (w_grant)
        SLOT_VID: r_vram_address <= vid_address;
        SLOT_WR: begin
          r_vram_address <= w_head_addr;
          r_vram_wdata   <= w_head_data;
          r_vram_we      <= 1'b1;
        end
        SLOT_RD:  r_vram_address <= cpu_address;
        default:  ;
      endcase
      if (r_slot[RD_LATENCY-2] == SLOT_VID) r_vid_data  <= vram_q;
      if (r_slot[RD_LATENCY-2] == SLOT_RD)  r_cpu_rdata <= vram_q;
    end
  end

  assign vid_valid    = (r_slot[RD_LATENCY-1] == SLOT_VID);
  assign vid_data     = r_vid_data;
  assign cpu_ack      = w_ack;
  assign cpu_rdata    = r_cpu_rdata;
  assign vram_address = r_vram_address;
  assign vram_wdata   = r_vram_wdata;
  assign vram_we      = r_vram_we;

endmodule

// File: tb/tb_vram_arbiter.sv
// Randomized bench for vram_arbiter with a queue-based reference model and RAM model.
module tb_vram_arbiter;
  localparam int AW    = 18;
  localparam int DW    = 8;
  localparam int DEPTH = 4;
  localparam int NCYC  = 2600;
  localparam int RST_A = 135;
  localparam int RST_B = 1500;

  typedef struct packed { logic [AW-1:0] a; logic [DW-1:0] d; } wr_t;
  typedef struct packed { logic we; logic [AW-1:0] a; logic [DW-1:0] d; } txn_t;

  logic          clock = 1'b0;
  logic          reset_n;
  logic          vid_req;
  logic [AW-1:0] vid_address;
  logic          vid_valid;
  logic [DW-1:0] vid_data;
  logic          cpu_req;
  logic          cpu_we;
  logic [AW-1:0] cpu_address;
  logic [DW-1:0] cpu_wdata;
  logic          cpu_ack;
  logic [DW-1:0] cpu_rdata;
  logic [AW-1:0] vram_address;
  logic [DW-1:0] vram_wdata;
  logic          vram_we;
  logic [DW-1:0] vram_q;

  vram_arbiter #(.AW(AW), .DW(DW), .WFIFO_DEPTH(DEPTH)) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .vid_req      (vid_req),
    .vid_address  (vid_address),
    .vid_valid    (vid_valid),
    .vid_data     (vid_data),
    .cpu_req      (cpu_req),
    .cpu_we       (cpu_we),
    .cpu_address  (cpu_address),
    .cpu_wdata    (cpu_wdata),
    .cpu_ack      (cpu_ack),
    .cpu_rdata    (cpu_rdata),
    .vram_address (vram_address),
    .vram_wdata   (vram_wdata),
    .vram_we      (vram_we),
    .vram_q       (vram_q)
  );

  always #5 clock = ~clock;

  // Power-up RAM contents: a fixed scramble of the address.
  function automatic logic [DW-1:0] init_byte(input logic [AW-1:0] a);
    logic [7:0] x;
    x = a[7:0] ^ a[15:8] ^ {6'd0, a[17:16]};
    return 8'(x * 8'd29 + 8'd7);
  endfunction

  // RAM: registered address, unregistered output; unwritten cells read their power-up value.
  logic [DW-1:0] ram   [0:(1<<AW)-1];
  bit            ram_v [0:(1<<AW)-1];
  logic [AW-1:0] ram_addr_q = '0;
  always @(posedge clock) begin
    if (vram_we) begin
      ram[vram_address]   <= vram_wdata;
      ram_v[vram_address] <= 1'b1;
    end
    ram_addr_q <= vram_address;
  end
  assign vram_q = ram_v[ram_addr_q] ? ram[ram_addr_q] : init_byte(ram_addr_q);

  // Reference model state.
  logic [DW-1:0] mdl_mem [0:(1<<AW)-1];
  bit            mdl_v   [0:(1<<AW)-1];
  wr_t           wq [$];
  txn_t          scr [$];
  bit            rd_busy, rd_pend, pw_v;
  logic [AW-1:0] pw_a;
  logic [DW-1:0] pw_d;
  bit            e_vid [8];
  bit            e_ack [8];
  bit            e_rdack [8];
  logic [DW-1:0] e_vdata [8];
  logic [DW-1:0] e_rdata [8];
  logic [AW-1:0] m_vaddr, n_vaddr;
  logic [DW-1:0] m_wdata, n_wdata, m_rdata;
  logic          m_we, n_we;

  int            cyc;
  int unsigned   n_checks = 0;
  int unsigned   n_fail   = 0;

  function automatic logic [DW-1:0] mread(input logic [AW-1:0] a);
    return mdl_v[a] ? mdl_mem[a] : init_byte(a);
  endfunction

  function automatic txn_t mk_txn(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    txn_t t;
    t.we = we; t.a = a; t.d = d;
    return t;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=0x%0h exp=0x%0h", tag, cyc, got, exp);
    end
  endtask

  task automatic check_zero_outputs(input string tag);
    check_eq({tag, ".vid_valid"},    32'(vid_valid),    32'd0);
    check_eq({tag, ".vid_data"},     32'(vid_data),     32'd0);
    check_eq({tag, ".cpu_ack"},      32'(cpu_ack),      32'd0);
    check_eq({tag, ".cpu_rdata"},    32'(cpu_rdata),    32'd0);
    check_eq({tag, ".vram_we"},      32'(vram_we),      32'd0);
    check_eq({tag, ".vram_address"}, 32'(vram_address), 32'd0);
    check_eq({tag, ".vram_wdata"},   32'(vram_wdata),   32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog cyc=%0d got=running exp=finished", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int   sl;
    int   sz;
    int   last_vid;
    bit   ack_now, do_push, act, prev_ack;
    txn_t t;
    wr_t  w;

    reset_n = 1'b0; vid_req = 1'b0; vid_address = '0;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_address = '0; cpu_wdata = '0;
    rd_busy = 1'b0; rd_pend = 1'b0; pw_v = 1'b0; pw_a = '0; pw_d = '0;
    n_vaddr = '0; n_we = 1'b0; n_wdata = '0; m_rdata = '0;
    act = 1'b0; prev_ack = 1'b0; last_vid = -100; t = '0; cyc = -1;
    for (int i = 0; i < 8; i++) begin
      e_vid[i] = 1'b0; e_ack[i] = 1'b0; e_rdack[i] = 1'b0; e_vdata[i] = '0; e_rdata[i] = '0;
    end
    repeat (3) @(posedge clock);
    #1;
    check_zero_outputs("por");
    reset_n = 1'b1;

    for (cyc = 0; cyc < NCYC; cyc++) begin
      @(posedge clock);
      #1;
      sl = cyc & 7;
      m_vaddr = n_vaddr; m_we = n_we; m_wdata = n_wdata;

      if (cyc == RST_A || cyc == RST_B) begin
        reset_n = 1'b0;
        #1;
        check_zero_outputs("rst");
        vid_req = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0;
        act = 1'b0; prev_ack = 1'b0;
        scr.delete(); wq.delete();
        rd_busy = 1'b0; rd_pend = 1'b0; pw_v = 1'b0;
        for (int i = 0; i < 8; i++) begin e_vid[i] = 1'b0; e_ack[i] = 1'b0; e_rdack[i] = 1'b0; end
        n_vaddr = '0; n_we = 1'b0; n_wdata = '0; m_rdata = '0;
        continue;
      end
      reset_n = 1'b1;

      // Compare outputs for this cycle.
      check_eq("vid_valid", 32'(vid_valid), 32'(e_vid[sl]));
      if (e_vid[sl]) check_eq("vid_data", 32'(vid_data), 32'(e_vdata[sl]));
      check_eq("cpu_ack", 32'(cpu_ack), 32'(e_ack[sl]));
      if (e_rdack[sl]) m_rdata = e_rdata[sl];
      check_eq("cpu_rdata", 32'(cpu_rdata), 32'(m_rdata));
      check_eq("vram_we", 32'(vram_we), 32'(m_we));
      check_eq("vram_address", 32'(vram_address), 32'(m_vaddr));
      check_eq("vram_wdata", 32'(vram_wdata), 32'(m_wdata));

      // Directed traffic scripts.
      if (cyc == 64) begin
        scr.push_back(mk_txn(1'b1, 18'h12345, 8'hA5));
        scr.push_back(mk_txn(1'b0, 18'h12345, 8'h00));
      end
      if (cyc == 110)
        for (int i = 0; i < 6; i++) scr.push_back(mk_txn(1'b1, AW'(18'h00100 + i), DW'(8'h30 + i)));
      if (cyc == RST_A + 2) scr.push_back(mk_txn(1'b0, 18'h00100, 8'h00));

      // CPU requester: holds each request through its ack cycle.
      if (prev_ack) act = 1'b0;
      if (!act) begin
        if (scr.size() > 0) begin
          t = scr.pop_front(); act = 1'b1;
        end else if (cyc >= 180 && $urandom_range(0, 2) == 0) begin
          t.we = 1'($urandom_range(0, 1));
          t.a  = AW'(18'h12340 + $urandom_range(0, 15));
          t.d  = DW'($urandom);
          act  = 1'b1;
        end
      end
      cpu_req = act; cpu_we = t.we; cpu_address = t.a; cpu_wdata = t.d;

      // Video requester: stream, then a dense burst, then random legal spacing.
      vid_req = 1'b0;
      if (cyc < 64) begin
        if (cyc % 4 == 0) begin vid_req = 1'b1; vid_address = AW'(cyc / 4); end
      end else if (cyc >= 110 && cyc < RST_A) begin
        vid_req = 1'b1; vid_address = AW'(18'h12340 + $urandom_range(0, 31));
      end else if (cyc >= 140 && cyc - last_vid >= 4 && $urandom_range(0, 3) != 0) begin
        vid_req = 1'b1; vid_address = AW'(18'h12340 + $urandom_range(0, 31));
      end
      if (vid_req) last_vid = cyc;

      // Reference model for this cycle.
      if (pw_v) begin mdl_mem[pw_a] = pw_d; mdl_v[pw_a] = 1'b1; pw_v = 1'b0; end
      ack_now = e_ack[sl];
      sz      = wq.size();
      do_push = cpu_req && cpu_we && !ack_now && sz < DEPTH;
      if (do_push) e_ack[(cyc + 1) & 7] = 1'b1;
      if (cpu_req && !cpu_we && !ack_now && !rd_busy) begin rd_busy = 1'b1; rd_pend = 1'b1; end
      n_we = 1'b0;
      if (vid_req) begin
        e_vid[(cyc + 3) & 7]   = 1'b1;
        e_vdata[(cyc + 3) & 7] = mread(vid_address);
        n_vaddr = vid_address;
      end else if (sz > 0) begin
        w = wq.pop_front();
        n_vaddr = w.a; n_we = 1'b1; n_wdata = w.d;
        pw_v = 1'b1; pw_a = w.a; pw_d = w.d;
      end else if (rd_pend) begin
        rd_pend = 1'b0;
        e_ack[(cyc + 3) & 7]   = 1'b1;
        e_rdack[(cyc + 3) & 7] = 1'b1;
        e_rdata[(cyc + 3) & 7] = mread(cpu_address);
        n_vaddr = cpu_address;
      end
      if (do_push) begin
        w.a = cpu_address; w.d = cpu_wdata;
        wq.push_back(w);
      end
      if (e_rdack[sl]) rd_busy = 1'b0;
      prev_ack = e_ack[sl];
      e_vid[sl] = 1'b0; e_ack[sl] = 1'b0; e_rdack[sl] = 1'b0;
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
